// File: rtl/viterbi_decoder_k3_if.sv
// Symbol-in / decision-out bundle for viterbi_decoder_k3.
// Decision outputs are registered and change only on accepted symbols or flush.
interface viterbi_decoder_k3_if #(
  parameter int PM_W = 4
);
  // sym is taken on the rising edge when sym_valid is high, with no ready signal.
  // flush wins over sym_valid. out_valid is a one-cycle pulse per decided bit.
  logic            sym_valid;
  logic [1:0]      sym;
  logic            flush;
  logic            out_valid;
  logic            out_bit;
  logic [PM_W-1:0] best_metric;

  modport master (
    output sym_valid, sym, flush,
    input  out_valid, out_bit, best_metric
  );

  modport slave (
    input  sym_valid, sym, flush,
    output out_valid, out_bit, best_metric
  );
endinterface

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision 4-state Viterbi decoder (K=3, p0 = u^u[-1], p1 = u^u[-1]^u[-2]).
// Register-exchange survivors of TB_DEPTH bits; one decision per accepted symbol once filled.
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 4
) (
  input logic                 CLK,
  input logic                 RST_N,
  viterbi_decoder_k3_if.slave bus
);

  localparam int              CW        = $clog2(TB_DEPTH + 1);
  localparam logic [CW-1:0]   FILL_LAST = CW'(TB_DEPTH - 1);
  localparam logic [CW-1:0]   FILL_MAX  = CW'(TB_DEPTH);
  localparam logic [PM_W-1:0] PM_MAX    = '1;
  localparam logic [PM_W-1:0] PM_INIT   = (PM_W >= 3) ? PM_W'(4) : PM_MAX;

  // State index is {a, b}: a = previous bit, b = the one before.
  logic [PM_W-1:0]     pm_q     [4];
  logic [TB_DEPTH-1:0] surv_q   [4];
  logic [CW-1:0]       fill_q;

  logic [PM_W-1:0]     cand0    [4];
  logic [PM_W-1:0]     cand1    [4];
  logic [PM_W-1:0]     pm_new   [4];
  logic [TB_DEPTH-1:0] surv_new [4];
  logic [PM_W-1:0]     pm_min;
  logic [1:0]          best;

  function automatic logic [1:0] branch_metric(logic [1:0] rx, logic u, logic a, logic b);
    logic [1:0] diff;
    diff = rx ^ {u ^ a ^ b, u ^ a};
    return {1'b0, diff[0]} + {1'b0, diff[1]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] x, logic [PM_W-1:0] y);
    logic [PM_W:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  // Next state {u, a} chooses between predecessors {a, 0} and {a, 1}; ties keep b = 0.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cand0[n] = sat_add(pm_q[{n[0], 1'b0}], PM_W'(branch_metric(bus.sym, n[1], n[0], 1'b0)));
      cand1[n] = sat_add(pm_q[{n[0], 1'b1}], PM_W'(branch_metric(bus.sym, n[1], n[0], 1'b1)));
      if (cand1[n] < cand0[n]) begin
        pm_new[n]   = cand1[n];
        surv_new[n] = {surv_q[{n[0], 1'b1}][TB_DEPTH-2:0], n[1]};
      end else begin
        pm_new[n]   = cand0[n];
        surv_new[n] = {surv_q[{n[0], 1'b0}][TB_DEPTH-2:0], n[1]};
      end
    end
    pm_min = pm_new[0];
    best   = 2'd0;
    for (int n = 1; n < 4; n++) begin
      if (pm_new[n] < pm_min) begin
        pm_min = pm_new[n];
        best   = 2'(n);
      end
    end
  end

  // best_metric accumulates the per-step normalisation offsets, i.e. the winner's
  // un-normalised metric, so it reads 0 on a clean stream and counts corrected errors.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
      fill_q          <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_bit     <= 1'b0;
      bus.best_metric <= '0;
    end else if (bus.flush) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : PM_INIT;
        surv_q[s] <= '0;
      end
      fill_q          <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_bit     <= 1'b0;
      bus.best_metric <= '0;
    end else if (bus.sym_valid) begin
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= pm_new[s] - pm_min;
        surv_q[s] <= surv_new[s];
      end
      if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
      bus.out_valid   <= (fill_q >= FILL_LAST);
      if (fill_q >= FILL_LAST) bus.out_bit <= surv_new[best][TB_DEPTH-1];
      bus.best_metric <= sat_add(bus.best_metric, pm_min);
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Randomised bench for viterbi_decoder_k3 against a full-history trellis model.
// Clean streams are also compared directly with the transmitted information bits.
module tb_viterbi_decoder_k3;

  localparam int TB_DEPTH = 15;
  localparam int PM_W     = 4;
  localparam int PM_CAP   = (1 << PM_W) - 1;
  localparam int INIT_PM  = (4 > PM_CAP) ? PM_CAP : 4;
  localparam int MAXL     = 1024;

  // clock / reset
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  viterbi_decoder_k3_if #(.PM_W(PM_W)) bus ();

  viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_pulse  = 0;
  logic [0:0]  exp_q [$];
  bit          got_q [$];
  bit          info_q [$];
  bit          exp_v;

  // reference model: un-normalised metrics and whole path histories per state
  int             m_pm   [4];
  bit [MAXL-1:0]  m_path [4];
  int             m_n;
  int             m_best;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc_sym(int u, int a, int b);
    return {1'(u ^ a ^ b), 1'(u ^ a)};
  endfunction

  function automatic int hamming(logic [1:0] x, logic [1:0] y);
    logic [1:0] d;
    d = x ^ y;
    return int'(d[0]) + int'(d[1]);
  endfunction

  function automatic void model_init();
    for (int s = 0; s < 4; s++) begin
      m_pm[s]   = (s == 0) ? 0 : INIT_PM;
      m_path[s] = '0;
    end
    m_n    = 0;
    m_best = 0;
    exp_q.delete();
  endfunction

  // Relax every branch forward from each state; scanning predecessors in ascending
  // order means the b = 0 predecessor keeps a tie.
  task automatic model_step(input logic [1:0] s);
    int            npm   [4];
    bit [MAXL-1:0] npath [4];
    int            best;
    int            nx;
    int            c;
    for (int n = 0; n < 4; n++) begin
      npm[n]   = 1 << 30;
      npath[n] = '0;
    end
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        nx = u * 2 + p / 2;
        c  = m_pm[p] + hamming(s, enc_sym(u, p / 2, p % 2));
        if (c < npm[nx]) begin
          npm[nx]         = c;
          npath[nx]       = m_path[p];
          npath[nx][m_n]  = 1'(u);
        end
      end
    end
    best = 0;
    for (int n = 1; n < 4; n++) if (npm[n] < npm[best]) best = n;
    m_pm   = npm;
    m_path = npath;
    m_n++;
    m_best = (npm[best] > PM_CAP) ? PM_CAP : npm[best];
    if (m_n >= TB_DEPTH) begin
      exp_v = 1'b1;
      exp_q.push_back(m_path[best][m_n - TB_DEPTH]);
    end
  endtask

  // driver: one clock cycle with the given inputs, then check the registered outputs
  task automatic step(input logic v, input logic [1:0] s, input logic f);
    @(negedge CLK);
    bus.sym_valid = v;
    bus.sym       = s;
    bus.flush     = f;
    exp_v         = 1'b0;
    if (f) model_init();
    else if (v) model_step(s);
    @(posedge CLK);
    #1;
    check_eq("out_valid", bus.out_valid, exp_v);
    if (bus.out_valid) begin
      n_pulse++;
      got_q.push_back(bus.out_bit);
      if (exp_q.size() > 0) check_eq("out_bit", bus.out_bit, exp_q.pop_front());
    end
    check_eq("best_metric", bus.best_metric, m_best);
  endtask

  // Flush (with a valid symbol that must be dropped), then send info_q plus the zero tail.
  task automatic send_stream(input int gap_max, input int err_at, input logic [1:0] err_mask,
                             input int stop_after);
    int a, b, u, total;
    logic [1:0] s;
    step(1'b1, 2'($urandom), 1'b1);
    got_q.delete();
    n_pulse = 0;
    a = 0;
    b = 0;
    total = info_q.size() + TB_DEPTH - 1;
    if (stop_after >= 0 && stop_after < total) total = stop_after;
    for (int i = 0; i < total; i++) begin
      u = (i < info_q.size()) ? int'(info_q[i]) : 0;
      s = enc_sym(u, a, b);
      b = a;
      a = u;
      if (i == err_at) s = s ^ err_mask;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step(1'b0, 2'($urandom), 1'b0);
      step(1'b1, s, 1'b0);
    end
  endtask

  task automatic check_decoded();
    check_eq("decoded_count", got_q.size(), info_q.size());
    for (int i = 0; i < info_q.size() && i < got_q.size(); i++)
      check_eq("decoded_bit", got_q[i], info_q[i]);
  endtask

  task automatic random_info(input int n);
    info_q.delete();
    repeat (n) info_q.push_back(1'($urandom));
  endtask

  // noisy stream with gaps, occasional flushes and bit errors; model is the judge
  task automatic random_session(input int nsym);
    int a, b, u, r;
    logic [1:0] s;
    step(1'b0, 2'b00, 1'b1);
    a = 0;
    b = 0;
    for (int i = 0; i < nsym; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1'b1, 2'($urandom), 1'b1);
        a = 0;
        b = 0;
      end else if (r < 20) begin
        step(1'b0, 2'($urandom), 1'b0);
      end else begin
        u = $urandom_range(0, 1);
        s = enc_sym(u, a, b);
        b = a;
        a = u;
        if ($urandom_range(0, 99) < 4) s = s ^ 2'($urandom_range(1, 3));
        step(1'b1, s, 1'b0);
      end
    end
  endtask

  initial begin
    bus.sym_valid = 1'b0;
    bus.sym       = 2'b00;
    bus.flush     = 1'b0;
    model_init();

    // reset held with sym_valid toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      bus.sym_valid = ~bus.sym_valid;
      bus.sym       = 2'($urandom);
      @(posedge CLK);
      #1;
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_out_bit", bus.out_bit, 0);
      check_eq("rst_best_metric", bus.best_metric, 0);
    end
    @(negedge CLK);
    bus.sym_valid = 1'b0;
    RST_N = 1'b1;

    // all-zero stream
    got_q.delete();
    n_pulse = 0;
    repeat (40) step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    check_eq("zero_pulses", n_pulse, 40 - TB_DEPTH + 1);
    for (int i = 0; i < got_q.size(); i++) check_eq("zero_bit", got_q[i], 0);

    // clean known sequence
    info_q = '{1, 0, 1, 1, 0, 0};
    send_stream(0, -1, 2'b00, -1);
    check_decoded();
    check_eq("known_metric", bus.best_metric, 0);

    // single error on the third symbol (01 -> 00)
    send_stream(0, 2, 2'b01, -1);
    check_decoded();
    check_eq("err_metric", bus.best_metric, 1);

    // same sequence with stalls
    send_stream(3, -1, 2'b00, -1);
    check_decoded();

    // flush with sym_valid after the 10th symbol, then a fresh stream
    random_info(30);
    send_stream(0, -1, 2'b00, 10);
    random_info(12);
    send_stream(0, -1, 2'b00, -1);
    check_decoded();

    // mid-stream asynchronous reset while a decision is showing
    random_info(20);
    send_stream(0, -1, 2'b00, 18);
    #2;
    RST_N = 1'b0;
    #1;
    check_eq("async_out_valid", bus.out_valid, 0);
    check_eq("async_out_bit", bus.out_bit, 0);
    check_eq("async_best_metric", bus.best_metric, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    model_init();
    random_info(25);
    send_stream(1, -1, 2'b00, -1);
    check_decoded();

    // longer clean random stream with gaps
    random_info(60);
    send_stream(2, -1, 2'b00, -1);
    check_decoded();

    // noisy random sessions checked against the model
    random_session(300);
    random_session(300);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
